div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
- Round-robin scheduler that shares one pipelined 16-bit divider core between NREQ requesters.
- Requesters present operands with a valid/ready handshake. The scheduler drives the core's operand inputs and tracks each issued operation through a tag/valid delay line.
- It returns quotient/remainder to the originating requester with a one-hot response strobe.
- It sits between the arithmetic clients (e.g. gain/normalisation units) and the single divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand/result width.
- DIV_LAT, 20, core latency in cycles from operands applied to quotient/remainder valid.
- TAGW, clog2(NREQ), tag width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_dividend  in  NREQ*W  packed dividends; requester i at bits [i*W +: W].
- req_divisor  in  NREQ*W  packed divisors, same packing.
- div_dividend  out  W  registered dividend to core.
- div_divisor  out  W  registered divisor to core.
- div_rfd  in  1  core ready-for-data.
- div_quotient  in  W  core quotient.
- div_remainder  in  W  core remainder.
- rsp_valid  out  NREQ  one-hot response strobe, 1 cycle.
- rsp_quotient  out  W  registered quotient.
- rsp_remainder  out  W  registered remainder.
- rsp_dbz  out  1  divide-by-zero flag, qualified by any rsp_valid bit.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. Reset takes priority over all other activity.
- Reset values:
  - rr_ptr=0; delay line valid bits all 0.
  - div_dividend=0, div_divisor=0.
  - rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0, busy=0.
  - req_ready=0 while rst=1.
- Arbitration (combinational):
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready[i]=1 only for that i, and only when div_rfd=1 and rst=0.
  - No grant when div_rfd=0 or no valid request.
- Accept: a transfer occurs at an edge where req_valid[i]&req_ready[i]. At that edge:
  - div_dividend/div_divisor load requester i's operands.
  - Delay line stage 0 loads {valid=1, tag=i, dbz=(divisor==0)}.
  - rr_ptr <= (i+1) mod NREQ.
- No accept: rr_ptr, div_dividend and div_divisor hold; stage 0 loads valid=0.
- Delay line:
  - DIV_LAT stages of {valid, tag, dbz}, shifting every cycle unconditionally. The core pipeline always advances; div_rfd gates issue only.
- Response timing:
  - When the last stage is valid, at the next edge: rsp_valid[tag]<=1, rsp_quotient<=div_quotient, rsp_remainder<=div_remainder, rsp_dbz<=dbz.
  - Otherwise rsp_valid<=0 and the data registers hold.
  - Accept at edge k gives rsp_valid high in the cycle after edge k+DIV_LAT+1. Total latency is DIV_LAT+1 cycles.
- Divide by zero:
  - The operation is still issued, so ordering and latency are unchanged.
  - Response forced to quotient={W{1}}, remainder=0, rsp_dbz=1. Core outputs are ignored for that slot.
- Throughput and ordering:
  - One accept per cycle, back-to-back allowed.
  - Responses return in global issue order; there is no per-requester limit.
- busy = OR of all delay-line valid bits plus the response stage.
- Simultaneous accept and response on the same edge are independent; both take effect.
- Reset mid-operation: in-flight operations are discarded and no rsp_valid is emitted for them.
- A requester may drop req_valid without a grant; no state is retained.

Test Plan:
- Single op, req 0: 1000/7 with rfd=1 -> req_ready[0]=1 for 1 cycle; rsp_valid=4'b0001 exactly DIV_LAT+1 cycles later; q=142, r=6, dbz=0.
- All 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 with one accept per cycle; responses in the same order, one per cycle.
- Divisor 0 on req 2: 55/0 -> rsp_valid=4'b0100, q=16'hFFFF, r=0, rsp_dbz=1.
- div_rfd=0 while req 1 valid for 5 cycles -> req_ready=0 and rr_ptr unchanged; grant to req 1 on the first cycle rfd returns to 1.
- Issue 3 ops, assert rst 5 cycles later for 1 cycle -> no rsp_valid ever emitted for those ops; busy=0 after reset; a new op 9/3 then returns q=3, r=0.
- rr_ptr=2 with req 0 and req 3 valid -> grant 3 first, then 0.

Source files
------------

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one pipelined divider core between NREQ requesters.
// A tag/valid delay line tracks each issued operation so the result returns to its requester.
module div_share_sched #(
    parameter int  NREQ    = 4,
    parameter int  W       = 16,
    parameter int  DIV_LAT = 20,
    localparam int TAGW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    input  logic              div_rfd,
    input  logic [W-1:0]      div_quotient,
    input  logic [W-1:0]      div_remainder,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_quotient,
    output logic [W-1:0]      rsp_remainder,
    output logic              rsp_dbz,
    output logic              busy
);

    logic [TAGW-1:0] r_rr_ptr;
    logic [W-1:0]    r_div_dividend;
    logic [W-1:0]    r_div_divisor;
    logic [NREQ-1:0] r_rsp_valid;
    logic [W-1:0]    r_rsp_quotient;
    logic [W-1:0]    r_rsp_remainder;
    logic            r_rsp_dbz;

    // Stage 0 lines up with the core operand registers, stage DIV_LAT with the core outputs.
    logic [DIV_LAT:0] r_dl_vld;
    logic [TAGW-1:0]  r_dl_tag [0:DIV_LAT];
    logic             r_dl_dbz [0:DIV_LAT];

    logic            w_gnt_vld;
    logic [TAGW-1:0] w_gnt_idx;
    logic [TAGW:0]   w_sum;
    logic            w_accept;
    logic [NREQ-1:0] w_ready;
    logic [W-1:0]    w_op_dvd;
    logic [W-1:0]    w_op_dvs;
    logic [TAGW-1:0] w_next_ptr;
    logic [NREQ-1:0] w_rsp_onehot;

    // Round-robin search from r_rr_ptr; descending loop so the nearest valid requester wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = {TAGW{1'b0}};
        w_sum     = {(TAGW+1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (TAGW+1)'(k);
            w_sum = (w_sum >= (TAGW+1)'(NREQ)) ? (w_sum - (TAGW+1)'(NREQ)) : w_sum;
            w_gnt_vld = req_valid[w_sum[TAGW-1:0]] ? 1'b1 : w_gnt_vld;
            w_gnt_idx = req_valid[w_sum[TAGW-1:0]] ? w_sum[TAGW-1:0] : w_gnt_idx;
        end
    end

    // Grant qualification and operand selection for the winning requester.
    always_comb begin
        w_accept   = w_gnt_vld & div_rfd & ~rst;
        w_ready    = {NREQ{1'b0}};
        w_op_dvd   = {W{1'b0}};
        w_op_dvs   = {W{1'b0}};
        if (w_accept) begin
            w_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_ready = {NREQ{1'b0}};
        end
        for (int i = 0; i < NREQ; i++) begin
            w_op_dvd = (w_gnt_idx == TAGW'(i)) ? req_dividend[i*W +: W] : w_op_dvd;
            w_op_dvs = (w_gnt_idx == TAGW'(i)) ? req_divisor[i*W +: W]  : w_op_dvs;
        end
        w_next_ptr   = (w_gnt_idx == TAGW'(NREQ - 1)) ? {TAGW{1'b0}} : (w_gnt_idx + TAGW'(1));
        w_rsp_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_dl_tag[DIV_LAT];
    end

    // Issue registers and round-robin pointer; hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= {TAGW{1'b0}};
            r_div_dividend <= {W{1'b0}};
            r_div_divisor  <= {W{1'b0}};
        end else if (w_accept) begin
            r_rr_ptr       <= w_next_ptr;
            r_div_dividend <= w_op_dvd;
            r_div_divisor  <= w_op_dvs;
        end else begin
            r_rr_ptr       <= r_rr_ptr;
            r_div_dividend <= r_div_dividend;
            r_div_divisor  <= r_div_divisor;
        end
    end

    // Valid bits shift every cycle because the core pipeline never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_vld <= {(DIV_LAT+1){1'b0}};
        end else begin
            r_dl_vld <= {r_dl_vld[DIV_LAT-1:0], w_accept};
        end
    end

    // Tag/dbz payload travels alongside the valid bits; it is meaningless when the valid is low.
    always_ff @(posedge clk) begin
        r_dl_tag[0] <= w_gnt_idx;
        r_dl_dbz[0] <= w_accept & (w_op_dvs == {W{1'b0}});
        for (int s = 1; s <= DIV_LAT; s++) begin
            r_dl_tag[s] <= r_dl_tag[s-1];
            r_dl_dbz[s] <= r_dl_dbz[s-1];
        end
    end

    // Response stage; divide-by-zero slots override whatever the core produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid     <= {NREQ{1'b0}};
            r_rsp_quotient  <= {W{1'b0}};
            r_rsp_remainder <= {W{1'b0}};
            r_rsp_dbz       <= 1'b0;
        end else if (r_dl_vld[DIV_LAT]) begin
            r_rsp_valid     <= w_rsp_onehot;
            r_rsp_quotient  <= r_dl_dbz[DIV_LAT] ? {W{1'b1}} : div_quotient;
            r_rsp_remainder <= r_dl_dbz[DIV_LAT] ? {W{1'b0}} : div_remainder;
            r_rsp_dbz       <= r_dl_dbz[DIV_LAT];
        end else begin
            r_rsp_valid     <= {NREQ{1'b0}};
            r_rsp_quotient  <= r_rsp_quotient;
            r_rsp_remainder <= r_rsp_remainder;
            r_rsp_dbz       <= r_rsp_dbz;
        end
    end

    assign req_ready     = w_ready;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_dbz       = r_rsp_dbz;
    assign busy          = (|r_dl_vld) | (|r_rsp_valid);

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched: a pipelined divider stand-in, a queue-based reference
// model of grants and responses, and directed plus randomized scenarios.
module tb_div_share_sched;
    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int DIV_LAT = 20;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_rfd;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic              rsp_dbz;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int model_rr = 0;

    typedef struct {
        int          req;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;
    exp_t sb[$];

    div_share_sched #(.NREQ(NREQ), .W(W), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_rfd(div_rfd), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dbz(rsp_dbz), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: fixed DIV_LAT pipeline, garbage on divide-by-zero.
    logic [W-1:0] core_q [0:DIV_LAT-1];
    logic [W-1:0] core_r [0:DIV_LAT-1];
    always @(posedge clk) begin
        core_q[0] <= (div_divisor == 16'd0) ? 16'hDEAD : div_dividend / div_divisor;
        core_r[0] <= (div_divisor == 16'd0) ? 16'hBEEF : div_dividend % div_divisor;
        for (int s = 1; s < DIV_LAT; s++) begin
            core_q[s] <= core_q[s-1];
            core_r[s] <= core_r[s-1];
        end
    end
    assign div_quotient  = core_q[DIV_LAT-1];
    assign div_remainder = core_r[DIV_LAT-1];

    // Reference model: round-robin rule plus a queue of expected responses with due cycles.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rv;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_busy;
        int              g;
        int              idx;
        exp_t            e;
        if (mon_en) begin
            exp_busy = (sb.size() != 0);
            exp_rv   = '0;
            if (sb.size() != 0 && sb[0].due == cyc) exp_rv[sb[0].req] = 1'b1;
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL mon_rsp_valid: got %b want %b cyc %0d", rsp_valid, exp_rv, cyc);
            end
            if (exp_rv != '0) begin
                checks++;
                if ({rsp_quotient, rsp_remainder, rsp_dbz} !== {sb[0].q, sb[0].r, sb[0].dbz}) begin
                    errors++;
                    $display("FAIL mon_rsp_data: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                             rsp_quotient, rsp_remainder, rsp_dbz, sb[0].q, sb[0].r, sb[0].dbz);
                end
                void'(sb.pop_front());
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL mon_busy: got %b want %b cyc %0d", busy, exp_busy, cyc);
            end
            exp_rdy = '0;
            if (rst) begin
                sb.delete();
                model_rr = 0;
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (model_rr + k) % NREQ;
                    if (div_rfd && g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) begin
                    exp_rdy[g] = 1'b1;
                    e.req = g;
                    e.dbz = (req_divisor[g*W +: W] == 16'd0);
                    e.q   = e.dbz ? 16'hFFFF : req_dividend[g*W +: W] / req_divisor[g*W +: W];
                    e.r   = e.dbz ? 16'h0000 : req_dividend[g*W +: W] % req_divisor[g*W +: W];
                    e.due = cyc + DIV_LAT + 2;
                    sb.push_back(e);
                    model_rr = (g + 1) % NREQ;
                end
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL mon_req_ready: got %b want %b cyc %0d", req_ready, exp_rdy, cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output bit found);
        found = 1'b0;
        for (int n = 0; n < DIV_LAT + 20; n++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < DIV_LAT + 40; n++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; div_rfd = 1'b1; req_valid = '1;
        req_dividend = '0; req_divisor = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got dd=%h ds=%h rv=%b q=%h r=%h dbz=%b busy=%b rdy=%b want all zero",
                     div_dividend, div_divisor, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, busy, req_ready);
        end
        mon_en = 1'b1;
        next_cycle();
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        bit found;
        int acc;
        req_valid = 4'b0001;
        set_op(0, 16'd1000, 16'd7);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        acc = cyc + 1;
        next_cycle();
        req_valid = '0;
        wait_rsp(found);
        checks++;
        if (!found || rsp_valid !== 4'b0001 || (cyc - acc) != DIV_LAT + 1) begin
            errors++;
            $display("FAIL single_latency: got rv=%b lat=%0d want rv=0001 lat=%0d", rsp_valid, cyc - acc, DIV_LAT + 1);
        end
        checks++;
        if ({rsp_quotient, rsp_remainder, rsp_dbz} !== {16'd142, 16'd6, 1'b0}) begin
            errors++;
            $display("FAIL single_data: got q=%0d r=%0d dbz=%b want q=142 r=6 dbz=0", rsp_quotient, rsp_remainder, rsp_dbz);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] want;
        int seen;
        int last;
        pulse_reset();
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom_range(1, 300)));
            want = 4'b0001 << (n % 4);
            @(negedge clk);
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL b2b_grant%0d: got %b want %b", n, req_ready, want);
            end
            next_cycle();
        end
        req_valid = '0;
        seen = 0; last = 0;
        for (int n = 0; n < DIV_LAT + 20 && seen < 8; n++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                want = 4'b0001 << (seen % 4);
                checks++;
                if (rsp_valid !== want || (seen > 0 && cyc != last + 1)) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got %b gap %0d want %b gap 1", seen, rsp_valid, cyc - last, want);
                end
                last = cyc;
                seen++;
            end
        end
        checks++;
        if (seen != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses want 8", seen);
        end
        next_cycle();
    endtask

    task automatic test_dbz();
        bit found;
        req_valid = 4'b0100;
        set_op(2, 16'd55, 16'd0);
        next_cycle();
        req_valid = '0;
        wait_rsp(found);
        checks++;
        if (!found || {rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz} !== {4'b0100, 16'hFFFF, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL dbz_rsp: got rv=%b q=%h r=%h dbz=%b want rv=0100 q=ffff r=0000 dbz=1",
                     rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz);
        end
        next_cycle();
    endtask

    task automatic test_rfd_low();
        div_rfd = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 16'd500, 16'd9);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rfd_low%0d: got %b want 0000", n, req_ready);
            end
            next_cycle();
        end
        div_rfd = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rfd_return: got %b want 0010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit found;
        for (int n = 0; n < 3; n++) begin
            req_valid = 4'b0001 << n;
            set_op(n, 16'($urandom), 16'($urandom_range(1, 50)));
            next_cycle();
        end
        req_valid = '0;
        repeat (5) next_cycle();
        pulse_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy: got %b want 0", busy);
        end
        wait_rsp(found);
        checks++;
        if (found) begin
            errors++;
            $display("FAIL rstmid_stale: got rv=%b want no response", rsp_valid);
        end
        next_cycle();
        req_valid = 4'b0001;
        set_op(0, 16'd9, 16'd3);
        next_cycle();
        req_valid = '0;
        wait_rsp(found);
        checks++;
        if (!found || {rsp_valid, rsp_quotient, rsp_remainder} !== {4'b0001, 16'd3, 16'd0}) begin
            errors++;
            $display("FAIL rstmid_new: got rv=%b q=%0d r=%0d want rv=0001 q=3 r=0", rsp_valid, rsp_quotient, rsp_remainder);
        end
        next_cycle();
    endtask

    task automatic test_rr_wrap();
        pulse_reset();
        req_valid = 4'b0010;
        set_op(1, 16'd10, 16'd2);
        next_cycle();
        req_valid = 4'b1001;
        set_op(0, 16'd77, 16'd5);
        set_op(3, 16'd88, 16'd6);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rr_first: got %b want 1000", req_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_second: got %b want 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            div_rfd   = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NREQ; i++)
                set_op(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000)));
            next_cycle();
        end
        rst = 1'b0; req_valid = '0; div_rfd = 1'b1;
        wait_idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_dbz();
        test_rfd_low();
        test_reset_mid();
        test_rr_wrap();
        test_random();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
